// File: rtl/blake2_ctrl.sv
// Byte-stream front end for a BLAKE2 compression core: splits the message into
// BB-byte blocks, zero-pads the final block and tracks the total byte count.
// Optional keyed mode is enabled by defining BLAKE2_CTRL_KEY_EN.
//
// state | meaning
// IDLE  | no message; counters and flags clear
// LOAD  | accepting stream bytes and forwarding them to the core
// PAD   | emitting 0x00 fill bytes up to the end of the block
// WAIT  | block complete; waiting for the core to finish compressing it
// DONE  | one-cycle digest-ready pulse
module blake2_ctrl #(
    parameter int BB   = 128,
    parameter int LL_W = 64
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            s_valid_i,
    input  logic [7:0]      s_data_i,
    input  logic            s_last_i,
    output logic            s_ready_o,
    input  logic [7:0]      kk_i,
    output logic            core_data_v_o,
    output logic [7:0]      core_data_o,
    output logic            core_block_first_o,
    output logic            core_block_last_o,
    output logic [LL_W-1:0] core_ll_o,
    input  logic            core_valid_i,
    output logic            busy_o,
    output logic            done_o
);
    localparam int            CW      = $clog2(BB);
    localparam logic [CW-1:0] CNT_MAX = CW'(BB - 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_PAD  = 3'd2;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [LL_W-1:0] ll_q, ll_d;
    logic            first_q, first_d;
    logic            last_q, last_d;
    logic            accept;
    logic            cnt_end;
    logic            pad_go;

`ifdef BLAKE2_CTRL_KEY_EN
    logic [7:0]  kk_q, kk_d;
    logic        key_q, key_d;
    logic        kk_sample;
    logic        key_now;
    logic        key_end;
    logic [7:0]  kk_cur;
    logic [15:0] kk_last;

    // kk_i is only meaningful on the very first byte of a message
    assign kk_sample = accept && first_q && (cnt_q == '0);
    assign kk_cur    = kk_sample ? kk_i : kk_q;
    assign key_now   = kk_sample ? (kk_i != 8'h00) : key_q;
    assign kk_last   = 16'(kk_cur) - 16'd1;
    assign key_end   = key_now && ((16'(cnt_q) == kk_last) || s_last_i);
`else
    logic unused_kk;
    assign unused_kk = ^kk_i;
`endif

    assign accept  = (state_q == ST_LOAD) && s_valid_i;
    assign cnt_end = (cnt_q == CNT_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ll_d    = ll_q;
        first_d = first_q;
        last_d  = last_q;
        pad_go  = 1'b0;
`ifdef BLAKE2_CTRL_KEY_EN
        kk_d    = kk_q;
        key_d   = key_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (s_valid_i) begin
                    state_d = ST_LOAD;
                    first_d = 1'b1;
                end
            end
            ST_LOAD: begin
                if (s_valid_i) begin
                    cnt_d  = cnt_q + CW'(1);
                    ll_d   = ll_q + LL_W'(1);
                    pad_go = s_last_i;
                    if (s_last_i) begin
                        last_d = 1'b1;
                    end
`ifdef BLAKE2_CTRL_KEY_EN
                    if (kk_sample) begin
                        kk_d = kk_i;
                    end
                    // key bytes are not counted individually; the whole key block counts as BB
                    if (key_now) begin
                        key_d  = !key_end;
                        ll_d   = key_end ? (ll_q + LL_W'(BB)) : ll_q;
                        pad_go = key_end;
                    end
`endif
                    if (cnt_end) begin
                        state_d = ST_WAIT;
                    end else if (pad_go) begin
                        state_d = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_end) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (core_valid_i) begin
                    first_d = 1'b0;
                    state_d = last_q ? ST_DONE : ST_LOAD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                ll_d    = '0;
                first_d = 1'b0;
                last_d  = 1'b0;
`ifdef BLAKE2_CTRL_KEY_EN
                kk_d    = 8'h00;
                key_d   = 1'b0;
`endif
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                ll_d    = '0;
                first_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ll_q    <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
`ifdef BLAKE2_CTRL_KEY_EN
            kk_q    <= 8'h00;
            key_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ll_q    <= ll_d;
            first_q <= first_d;
            last_q  <= last_d;
`ifdef BLAKE2_CTRL_KEY_EN
            kk_q    <= kk_d;
            key_q   <= key_d;
`endif
        end
    end

    assign s_ready_o          = (state_q == ST_LOAD);
    assign core_data_v_o      = accept || (state_q == ST_PAD);
    assign core_data_o        = accept ? s_data_i : 8'h00;
    assign core_block_first_o = first_q;
    assign core_block_last_o  = last_q || (accept && s_last_i);
    // in LOAD the count already includes the byte being accepted this cycle
    assign core_ll_o          = (state_q == ST_LOAD) ? ll_d : ll_q;
    assign busy_o             = (state_q != ST_IDLE);
    assign done_o             = (state_q == ST_DONE);

endmodule

// File: tb/tb_blake2_ctrl.sv
// Directed bench for blake2_ctrl: expected core-side bytes go into a queue as
// stimulus is driven and are popped by a monitor whenever the DUT emits a byte.
module tb_blake2_ctrl;
    localparam int BB   = 128;
    localparam int LL_W = 64;

    logic            clk = 1'b0;
    logic            nreset = 1'b0;
    logic            s_valid = 1'b0;
    logic [7:0]      s_data = 8'h00;
    logic            s_last = 1'b0;
    logic [7:0]      kk = 8'h00;
    logic            core_valid = 1'b0;
    logic            s_ready_o;
    logic            core_data_v_o;
    logic [7:0]      core_data_o;
    logic            core_block_first_o;
    logic            core_block_last_o;
    logic [LL_W-1:0] core_ll_o;
    logic            busy_o;
    logic            done_o;

    blake2_ctrl #(.BB(BB), .LL_W(LL_W)) dut (
        .clk                (clk),
        .nreset             (nreset),
        .s_valid_i          (s_valid),
        .s_data_i           (s_data),
        .s_last_i           (s_last),
        .s_ready_o          (s_ready_o),
        .kk_i               (kk),
        .core_data_v_o      (core_data_v_o),
        .core_data_o        (core_data_o),
        .core_block_first_o (core_block_first_o),
        .core_block_last_o  (core_block_last_o),
        .core_ll_o          (core_ll_o),
        .core_valid_i       (core_valid),
        .busy_o             (busy_o),
        .done_o             (done_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]      data;
        logic            first;
        logic            last;
        logic [LL_W-1:0] ll;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t mon_got;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;

    always @(negedge clk) begin
        if (done_o) done_cnt++;
        if (core_data_v_o) begin
            mon_got.data  = core_data_o;
            mon_got.first = core_block_first_o;
            mon_got.last  = core_block_last_o;
            mon_got.ll    = core_ll_o;
            n_assert++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_byte observed=%h expected=no byte", mon_got);
            end
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                n_assert++;
                assert (mon_got === mon_e) else begin
                    n_fail++;
                    $error("FAIL core_byte observed{data,first,last,ll}=%h expected=%h", mon_got, mon_e);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [LL_W-1:0] got, input logic [LL_W-1:0] expv);
        n_assert++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
        end
    endtask

    task automatic timeout_fail(input string tag);
        n_assert++;
        n_fail++;
        $error("FAIL %s observed=timeout expected=event within bound", tag);
    endtask

    task automatic push(input logic [7:0] d, input bit f, input bit l, input longint ll);
        exp_t e;
        e.data  = d;
        e.first = f;
        e.last  = l;
        e.ll    = LL_W'(ll);
        exp_q.push_back(e);
    endtask

    function automatic logic [7:0] pat(input int i);
        logic [7:0] b;
        b = 8'(i);
        return 8'h61 + b;
    endfunction

    task automatic send_byte(input logic [7:0] d, input bit last);
        bit ok;
        ok = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = s_ready_o;
            @(posedge clk);
            #1;
        end
        if (!ok) timeout_fail("send_byte");
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
    endtask

    // Wait for the WAIT state, check it holds, release it with core_valid
    task automatic wait_block(input bit exp_done, input longint exp_ll);
        bit hit;
        int d0;
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            hit = busy_o && !s_ready_o && !core_data_v_o && !done_o;
            if (!hit) begin
                @(posedge clk);
                #1;
            end
        end
        if (!hit) begin
            timeout_fail("wait_state");
        end else begin
            check("queue_drained", LL_W'(exp_q.size()), '0);
            d0 = done_cnt;
            for (int c = 0; c < 3; c++) begin
                if (c > 0) begin
                    @(posedge clk);
                    #1;
                    @(negedge clk);
                end
                check("wait_ready_low", LL_W'(s_ready_o), '0);
                check("wait_ll_hold", core_ll_o, LL_W'(exp_ll));
            end
            @(posedge clk);
            #1;
            core_valid = 1'b1;
            @(posedge clk);
            #1;
            core_valid = 1'b0;
            @(negedge clk);
            if (exp_done) begin
                check("done_pulse", LL_W'({done_o, busy_o}), LL_W'(2'b11));
                @(posedge clk);
                #1;
                @(negedge clk);
                check("idle_after_done",
                      LL_W'({done_o, busy_o, core_block_first_o, core_block_last_o}), '0);
                check("idle_ll_clear", core_ll_o, '0);
                check("done_count", LL_W'(done_cnt), LL_W'(d0 + 1));
            end else begin
                check("wait_to_load", LL_W'({done_o, s_ready_o, core_block_first_o}), LL_W'(3'b010));
            end
        end
        @(posedge clk);
        #1;
    endtask

    // n message bytes after an optional nk-byte key; kk_drv is what is placed on kk_i
    task automatic run_msg(input int n, input int nk, input int kk_drv, input int ign);
        longint ll;
        bit     first;
        bit     lst;
        int     cnt;
        ll    = 0;
        first = 1'b1;
        cnt   = 0;
        kk    = 8'(kk_drv);
        if (nk > 0) begin
            for (int i = 0; i < nk; i++) begin
                lst = (n == 0) && (i == nk - 1);
                push(8'(8'hA0 + 8'(i)), first, lst, (i == nk - 1) ? longint'(BB) : 0);
                send_byte(8'(8'hA0 + 8'(i)), lst);
                cnt++;
            end
            ll = BB;
            for (int c = cnt; c < BB; c++) push(8'h00, first, n == 0, ll);
            wait_block(n == 0, ll);
            first = 1'b0;
            cnt   = 0;
        end
        for (int i = 0; i < n; i++) begin
            lst = (i == n - 1);
            if (i == ign) begin
                s_last = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                s_last = 1'b0;
            end
            ll++;
            push(pat(i), first, lst, ll);
            core_valid = (i >= 10) && (i <= 20);
            send_byte(pat(i), lst);
            core_valid = 1'b0;
            cnt++;
            if (lst) begin
                for (int c = cnt; c < BB; c++) push(8'h00, first, 1'b1, ll);
                wait_block(1'b1, ll);
            end else if (cnt == BB) begin
                wait_block(1'b0, ll);
                first = 1'b0;
                cnt   = 0;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=time limit reached expected=test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        s_valid = 1'b1;
        @(negedge clk);
        check("reset_outputs",
              LL_W'({s_ready_o, core_data_v_o, core_data_o, core_block_first_o,
                     core_block_last_o, busy_o, done_o}), '0);
        check("reset_ll", core_ll_o, '0);
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        nreset = 1'b1;
        @(negedge clk);
        check("idle_after_reset", LL_W'({busy_o, s_ready_o}), '0);
        @(posedge clk);
        #1;

        run_msg(3, 0, 0, -1);
        run_msg(128, 0, 0, -1);
        run_msg(129, 0, 0, 50);

        d0 = done_cnt;
        for (int i = 0; i < 60; i++) begin
            push(pat(i), 1'b1, 1'b0, i + 1);
            send_byte(pat(i), 1'b0);
        end
        nreset = 1'b0;
        s_valid = 1'b1;
        s_data = 8'h5A;
        @(negedge clk);
        check("midblock_reset_outputs",
              LL_W'({s_ready_o, core_data_v_o, core_data_o, core_block_first_o,
                     core_block_last_o, busy_o, done_o}), '0);
        check("midblock_reset_ll", core_ll_o, '0);
        s_valid = 1'b0;
        s_data = 8'h00;
        @(posedge clk);
        #1;
        nreset = 1'b1;
        @(negedge clk);
        check("idle_after_midblock_reset", LL_W'(busy_o), '0);
        check("abandoned_queue", LL_W'(exp_q.size()), '0);
        @(posedge clk);
        #1;
        run_msg(1, 0, 0, -1);
        check("no_stale_done", LL_W'(done_cnt), LL_W'(d0 + 1));

`ifdef BLAKE2_CTRL_KEY_EN
        run_msg(3, 32, 32, -1);
        run_msg(0, 16, 16, -1);
`else
        run_msg(3, 0, 32, -1);
`endif

        repeat (4) @(posedge clk);
        check("final_queue_empty", LL_W'(exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
